// File: rtl/softmax_arbiter.sv
// Round-robin arbiter sharing one softmax_approx engine among NUM_REQ requesters.
// Issues the engine start pulse, routes the done pulse back to the owner, aborts
// jobs that exceed a watchdog limit, and keeps a saturating busy-cycle counter.
module softmax_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned STAT_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  output logic                  sm_start,
  input  logic                  sm_done,
  output logic [NUM_REQ-1:0]    grant,
  output logic [ID_WIDTH-1:0]   grant_id,
  output logic [NUM_REQ-1:0]    req_done,
  output logic                  busy,
  output logic                  timeout,
  output logic                  err_sticky,
  input  logic                  clr_stats,
  output logic [STAT_WIDTH-1:0] busy_cycles
);

  localparam int unsigned CntWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StRelease
  } state_e;

  state_e              state;
  logic [ID_WIDTH-1:0] last_grant;
  logic [CntWidth-1:0] wait_cnt;
  logic                pick_valid;
  logic [ID_WIDTH-1:0] pick_id;
  logic                wd_fire;

  assign busy     = (state != StIdle);
  assign sm_start = (state == StIssue);
  // Done takes priority over the watchdog when both land in the same cycle.
  assign wd_fire  = (state == StWait) && !sm_done && (wait_cnt == CntMax);

  // Round-robin pick: first set request scanning upward from last_grant+1 with wrap.
  always_comb begin
    int unsigned idx;
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = ID_WIDTH'(idx);
      end
    end
  end

  // Main FSM with registered grant, completion and timeout pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      grant      <= '0;
      grant_id   <= '0;
      req_done   <= '0;
      timeout    <= 1'b0;
      wait_cnt   <= '0;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      case (state)
        StIdle: begin
          req_done <= '0;
          timeout  <= 1'b0;
          if (pick_valid) begin
            grant    <= NUM_REQ'(1) << pick_id;
            grant_id <= pick_id;
            state    <= StIssue;
          end
        end
        StIssue: begin
          wait_cnt <= '0;
          state    <= StWait;
        end
        StWait: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (sm_done) begin
            req_done <= grant;
            state    <= StRelease;
          end else if (wd_fire) begin
            timeout <= 1'b1;
            state   <= StRelease;
          end
        end
        StRelease: begin
          // Also serves as a bubble letting the engine return to idle.
          req_done   <= '0;
          timeout    <= 1'b0;
          last_grant <= grant_id;
          grant      <= '0;
          state      <= StIdle;
        end
        default: begin
          state <= StIdle;
          grant <= '0;
        end
      endcase
    end
  end

  // Statistics: saturating busy counter and sticky error flag, clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cycles <= '0;
      err_sticky  <= 1'b0;
    end else if (clr_stats) begin
      busy_cycles <= '0;
      err_sticky  <= 1'b0;
    end else begin
      if (busy && (busy_cycles != {STAT_WIDTH{1'b1}})) begin
        busy_cycles <= busy_cycles + 1'b1;
      end
      if (wd_fire) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_softmax_arbiter.sv
// Randomized transaction-level bench for softmax_arbiter: the bench plays the
// requesters and the engine, and predicts every job from round-robin rules.
module tb_softmax_arbiter;

  localparam int N   = 4;
  localparam int T   = 8;
  localparam int SW  = 5;
  localparam int SAT = 31;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic          sm_start;
  logic          sm_done;
  logic [N-1:0]  grant;
  logic [1:0]    grant_id;
  logic [N-1:0]  req_done;
  logic          busy;
  logic          timeout;
  logic          err_sticky;
  logic          clr_stats;
  logic [SW-1:0] busy_cycles;

  softmax_arbiter #(
    .NUM_REQ       (N),
    .TIMEOUT_CYCLES(T),
    .STAT_WIDTH    (SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .sm_start   (sm_start),
    .sm_done    (sm_done),
    .grant      (grant),
    .grant_id   (grant_id),
    .req_done   (req_done),
    .busy       (busy),
    .timeout    (timeout),
    .err_sticky (err_sticky),
    .clr_stats  (clr_stats),
    .busy_cycles(busy_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int           last_m;
  bit           err_m;
  int           bc_m;
  logic [N-1:0] req_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int off = 1; off <= N; off++) begin
      if (r[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  // Statistics update for one clock edge, using the clr_stats value seen at that edge.
  task automatic tick(input bit busy_before, input bit set_err);
    if (clr_stats) begin
      bc_m  = 0;
      err_m = 0;
    end else begin
      if (busy_before && bc_m < SAT) bc_m++;
      if (set_err) err_m = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit rnd_clr();
    return ($urandom_range(0, 29) == 0);
  endfunction

  task automatic check_all(input string ph, input int w, input bit busy_e, input bit start_e,
                           input logic [N-1:0] done_e, input bit to_e);
    logic [N-1:0] g_e;
    g_e = (w >= 0) ? N'(1 << w) : '0;
    check({ph, ".grant"}, 32'(grant), 32'(g_e));
    if (w >= 0) check({ph, ".grant_id"}, 32'(grant_id), 32'(w));
    check({ph, ".busy"}, 32'(busy), 32'(busy_e));
    check({ph, ".sm_start"}, 32'(sm_start), 32'(start_e));
    check({ph, ".req_done"}, 32'(req_done), 32'(done_e));
    check({ph, ".timeout"}, 32'(timeout), 32'(to_e));
    check({ph, ".err_sticky"}, 32'(err_sticky), 32'(err_m));
    check({ph, ".busy_cycles"}, 32'(busy_cycles), 32'(bc_m));
  endtask

  function automatic logic [N-1:0] wait_req(input int w);
    // Owner may drop req early; it must be ignored while the job runs.
    return ($urandom_range(0, 1) != 0) ? req_m : (req_m & ~N'(1 << w));
  endfunction

  task automatic run_job(input bit do_reset);
    int w;
    int k;
    bit done;
    bit fire;
    if (req_m == '0) begin
      repeat ($urandom_range(0, 2)) begin
        req       = '0;
        sm_done   = 1'($urandom_range(0, 1));
        clr_stats = rnd_clr();
        step();
        tick(0, 0);
        check_all("idle", -1, 0, 0, '0, 0);
      end
      req_m = N'($urandom_range(1, 15));
    end else if (!do_reset) begin
      req_m |= N'($urandom_range(0, 15));
    end
    w = pick(req_m, last_m);

    // IDLE -> ISSUE
    req       = req_m;
    sm_done   = 1'($urandom_range(0, 1));
    clr_stats = rnd_clr();
    step();
    tick(0, 0);
    check_all("issue", w, 1, 1, '0, 0);

    k = $urandom_range(0, T + 1);
    if ($urandom_range(0, 4) == 0) k = T - 1;

    // ISSUE -> WAIT; sm_done here must be ignored
    req       = wait_req(w);
    sm_done   = 1'($urandom_range(0, 1));
    clr_stats = rnd_clr();
    step();
    tick(1, 0);

    done = 0;
    fire = 0;
    for (int i = 0; ; i++) begin
      check_all("wait", w, 1, 0, '0, 0);
      if (do_reset && i == 2) begin
        rst_n     = 1'b0;
        sm_done   = 1'b0;
        clr_stats = 1'b0;
        req       = '0;
        #1;
        last_m = N - 1;
        err_m  = 0;
        bc_m   = 0;
        check_all("async_rst", -1, 0, 0, '0, 0);
        step();
        rst_n = 1'b1;
        req_m = N'(1);
        return;
      end
      sm_done   = (i == k);
      clr_stats = (i == T - 1) ? 1'b0 : rnd_clr();
      req       = wait_req(w);
      step();
      done = (i == k);
      fire = (i == T - 1) && !done;
      tick(1, fire);
      if (done || fire) break;
    end

    check_all("release", w, 1, 0, done ? N'(1 << w) : '0, !done);

    // RELEASE -> IDLE; owner drops its request, others may arrive
    req_m     = (req_m & ~N'(1 << w)) | (N'($urandom_range(0, 15)) & ~N'(1 << w));
    req       = req_m;
    sm_done   = 1'($urandom_range(0, 1));
    clr_stats = rnd_clr();
    step();
    tick(1, 0);
    last_m = w;
    check_all("back_idle", -1, 0, 0, '0, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    sm_done   = 1'b0;
    clr_stats = 1'b0;
    last_m    = N - 1;
    err_m     = 0;
    bc_m      = 0;
    req_m     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", -1, 0, 0, '0, 0);
    check("reset.grant_id", 32'(grant_id), 32'd0);
    rst_n = 1'b1;
    step();
    check_all("post_reset", -1, 0, 0, '0, 0);

    for (int j = 0; j < 80; j++) begin
      run_job(j == 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/softmax_arbiter.md
Name: softmax_arbiter

Overview:
- Shares one softmax_approx engine among NUM_REQ requesters (e.g. per-head attention pipelines) using round-robin arbitration.
- Drives the engine's start pulse and receives its done pulse.
- Exposes grant one-hot and grant_id so the top level can mux A_in and route A_out to the owner.
- Adds a watchdog timeout and a busy-cycle statistics counter.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
TIMEOUT_CYCLES, 1024, max WAIT cycles before abort (>=2)
STAT_WIDTH, 32, width of busy-cycle counter
ID_WIDTH, $clog2(NUM_REQ), derived; width of grant_id

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  level request per requester; held until its req_done/timeout
sm_start  output  1  one-cycle start pulse to softmax engine
sm_done  input  1  engine completion pulse
grant  output  NUM_REQ  one-hot current owner; all-zero when no owner
grant_id  output  ID_WIDTH  binary index of owner (mux select); valid while busy
req_done  output  NUM_REQ  one-cycle completion pulse to owner
busy  output  1  high whenever state != IDLE
timeout  output  1  one-cycle pulse on watchdog abort
err_sticky  output  1  set on any timeout; cleared only by clr_stats or reset
clr_stats  input  1  synchronous clear of busy_cycles and err_sticky
busy_cycles  output  STAT_WIDTH  saturating count of cycles with busy=1

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; grant=0; grant_id=0; req_done=0; timeout=0; err_sticky=0; busy_cycles=0.
  - last_grant=NUM_REQ-1, so req[0] has first priority.
  - Asserting reset mid-operation aborts immediately: sm_start=0; no req_done is issued. The engine is reset by the same rst_n.
- FSM states: IDLE, ISSUE, WAIT, RELEASE.
  - IDLE: when |req, select the first set bit scanning from last_grant+1 upward with wrap. Register grant and grant_id, go to ISSUE. If req=0, stay in IDLE.
  - ISSUE: sm_start=1 for exactly this cycle (decoded from state). Clear wait_cnt. Go to WAIT.
  - WAIT: wait_cnt increments each cycle.
    - sm_done=1: req_done[grant_id] <= 1, go to RELEASE.
    - Else if wait_cnt==TIMEOUT_CYCLES-1: timeout <= 1, err_sticky <= 1, go to RELEASE; no req_done.
    - sm_done and the timeout condition in the same cycle: done wins, no timeout.
  - RELEASE: req_done or timeout is high this cycle only. Grant is still held. last_grant <= grant_id. Next edge: grant <= 0, go to IDLE.
    - This cycle doubles as a bubble so the engine can return to its own IDLE before the next start.
- Latency:
  - req rising, sampled in IDLE -> grant and sm_start high on the next cycle.
  - sm_done sampled -> req_done high on the next cycle.
  - Minimum back-to-back start spacing is engine latency + 3 cycles.
- Handshake rules:
  - Requester keeps req high until it sees req_done or timeout, then drops it.
  - A req still high when the FSM reaches IDLE is treated as a new request, ranked last by round-robin.
  - req deassertion during ISSUE/WAIT is ignored; grant is held until RELEASE.
- sm_done outside WAIT (IDLE, ISSUE, RELEASE) is ignored and does not affect state or outputs.
- busy_cycles: +1 per cycle with busy=1, saturating at all-ones (no wrap). clr_stats has priority over increment in the same cycle.
- grant is always one-hot or zero; grant_id matches the set bit of grant.

Test Plan:
- Single request: req=4'b0100 at cycle 0 -> grant=4'b0100, grant_id=2, sm_start pulse at cycle 1. sm_done driven at cycle 10 -> req_done=4'b0100 at cycle 11, grant=0 and busy=0 at cycle 12. busy_cycles=11.
- Fairness: req=4'b1111 held, each done after 5 WAIT cycles -> grant order 0,1,2,3,0. Exactly one sm_start per grant; no starts closer than 8 cycles apart.
- Round-robin skip: after grant to 1, req=4'b0011 -> next grant 0 (wrap past 2,3). Then req=4'b0010 -> grant 1.
- Timeout: TIMEOUT_CYCLES=8, sm_done never arrives -> timeout pulse 8 cycles after WAIT entry; err_sticky=1; req_done never pulses. Next request is granted normally. clr_stats clears err_sticky and busy_cycles to 0.
- Tie: sm_done on the same cycle wait_cnt==TIMEOUT_CYCLES-1 -> req_done pulses, timeout=0, err_sticky unchanged. Spurious sm_done in IDLE -> no output change.
- Reset and saturation:
  - rst_n low mid-WAIT -> all outputs zero immediately. After release, req=4'b0001 gets grant 0 (priority restored).
  - STAT_WIDTH=4 with a long job -> busy_cycles stops at 15.
